// File: rtl/tex_sampler_pkg.sv
// Shared definitions for the texture sampler: texel format codes, blend width and the
// storage-format to A8R8G8B8 unpack function.
package tex_sampler_pkg;

  localparam int unsigned TEX_FORMAT_BITS = 3;
  localparam int unsigned TEX_BLEND_FRAC  = 8;

  localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_A8R8G8B8 = 3'd0;
  localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_R5G6B5   = 3'd1;
  localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_A1R5G5B5 = 3'd2;
  localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_A4R4G4B4 = 3'd3;
  localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_A8L8     = 3'd4;
  localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_L8       = 3'd5;
  localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_A8       = 3'd6;

  // Narrow channels widen by replicating their top bits into the vacated low bits.
  function automatic logic [31:0] tex_unpack(input logic [TEX_FORMAT_BITS-1:0] format,
                                             input logic [31:0] texel);
    logic [31:0] c;
    c = '0;
    case (format)
      TEX_FORMAT_A8R8G8B8: c = texel;
      TEX_FORMAT_R5G6B5:   c = {8'hFF, texel[15:11], texel[15:13], texel[10:5], texel[10:9],
                                texel[4:0], texel[4:2]};
      TEX_FORMAT_A1R5G5B5: c = {{8{texel[15]}}, texel[14:10], texel[14:12], texel[9:5],
                                texel[9:7], texel[4:0], texel[4:2]};
      TEX_FORMAT_A4R4G4B4: c = {texel[15:12], texel[15:12], texel[11:8], texel[11:8],
                                texel[7:4], texel[7:4], texel[3:0], texel[3:0]};
      TEX_FORMAT_A8L8:     c = {texel[15:8], {3{texel[7:0]}}};
      TEX_FORMAT_L8:       c = {8'hFF, {3{texel[7:0]}}};
      TEX_FORMAT_A8:       c = {texel[7:0], 24'h0};
      default:             c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tex_sampler_lerp.sv
// Four-channel combinational lerp of two A8R8G8B8 colours by one 8-bit weight:
// y = (a*(256-f) + b*f + 128) >> 8 per channel.
module tex_sampler_lerp import tex_sampler_pkg::*; (
  input  logic [31:0]               a,
  input  logic [31:0]               b,
  input  logic [TEX_BLEND_FRAC-1:0] f,
  output logic [31:0]               y
);

  for (genvar c = 0; c < 4; c++) begin : gen_ch
    logic [16:0] acc;
    // Sum never exceeds 255*256+128, so 17 bits hold it and the result fits 8 bits.
    assign acc = 17'(a[c*8 +: 8]) * (17'd256 - 17'(f)) + 17'(b[c*8 +: 8]) * 17'(f) + 17'd128;
    assign y[c*8 +: 8] = 8'(acc >> 8);
  end

endmodule

// File: rtl/tex_sampler.sv
// Texture filter: S1 unpack, S2 horizontal lerp, S3 vertical lerp, with one global stall.
// Optional perf counters enabled by defining TEX_SAMPLER_PERF_EN.
module tex_sampler import tex_sampler_pkg::*; #(
  parameter string       INSTANCE_ID = "",
  parameter int unsigned NUM_LANES   = 1,
  parameter int unsigned REQ_INFOW   = 1,
  parameter int unsigned FRAC_BITS   = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  input  logic [NUM_LANES-1:0]            req_mask,
  input  logic [TEX_FORMAT_BITS-1:0]      req_format,
  input  logic                            req_filter,
  input  logic [NUM_LANES*2*FRAC_BITS-1:0] req_blends,
  input  logic [NUM_LANES*4*32-1:0]       req_data,
  input  logic [REQ_INFOW-1:0]            req_info,
  output logic                            req_ready,
  output logic                            rsp_valid,
  output logic [NUM_LANES-1:0]            rsp_mask,
  output logic [NUM_LANES*32-1:0]         rsp_data,
  output logic [REQ_INFOW-1:0]            rsp_info,
`ifdef TEX_SAMPLER_PERF_EN
  output logic [31:0]                     perf_stalls,
  output logic [31:0]                     perf_reqs,
`endif
  input  logic                            rsp_ready
);

  if (FRAC_BITS != TEX_BLEND_FRAC) begin : gen_frac_check
    $error("%s: tex_sampler supports FRAC_BITS == 8 only", INSTANCE_ID);
  end

  logic                                          s1_valid, s2_valid, s3_valid;
  logic [NUM_LANES-1:0]                          s1_mask, s2_mask, s3_mask;
  logic [REQ_INFOW-1:0]                          s1_info, s2_info, s3_info;
  logic                                          s1_filter;
  logic [NUM_LANES-1:0][3:0][31:0]               s1_tex, unpacked;
  logic [NUM_LANES-1:0][TEX_BLEND_FRAC-1:0]      s1_fu, s1_fv, s2_fv;
  logic [NUM_LANES-1:0][31:0]                    s2_h0, s2_h1, s3_col;
  logic [NUM_LANES-1:0][31:0]                    lerp_h0, lerp_h1, lerp_v, h0_d, h1_d;
  logic                                          en;

  assign en        = ~s3_valid | rsp_ready;
  assign req_ready = en & ~reset;

  always_comb begin
    unpacked = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int k = 0; k < 4; k++) begin
        unpacked[l][k] = tex_unpack(req_format, req_data[(l*4+k)*32 +: 32]);
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : gen_lane
    tex_sampler_lerp u_lerp_h0 (.a(s1_tex[l][0]), .b(s1_tex[l][1]), .f(s1_fu[l]), .y(lerp_h0[l]));
    tex_sampler_lerp u_lerp_h1 (.a(s1_tex[l][2]), .b(s1_tex[l][3]), .f(s1_fu[l]), .y(lerp_h1[l]));
    tex_sampler_lerp u_lerp_v  (.a(s2_h0[l]), .b(s2_h1[l]), .f(s2_fv[l]), .y(lerp_v[l]));

    // Point mode feeds t0 to both rows; lerp(x, x, f) == x, so S3 passes it unchanged.
    assign h0_d[l] = s1_filter ? lerp_h0[l] : s1_tex[l][0];
    assign h1_d[l] = s1_filter ? lerp_h1[l] : s1_tex[l][0];

    assign rsp_data[l*32 +: 32] = s3_mask[l] ? s3_col[l] : 32'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_mask   <= '0;
      s1_info   <= '0;
      s1_filter <= 1'b0;
      s1_tex    <= '0;
      s1_fu     <= '0;
      s1_fv     <= '0;
      s2_valid  <= 1'b0;
      s2_mask   <= '0;
      s2_info   <= '0;
      s2_h0     <= '0;
      s2_h1     <= '0;
      s2_fv     <= '0;
      s3_valid  <= 1'b0;
      s3_mask   <= '0;
      s3_info   <= '0;
      s3_col    <= '0;
    end else if (en) begin
      s1_valid  <= req_valid;
      s1_mask   <= req_mask;
      s1_info   <= req_info;
      s1_filter <= req_filter;
      s1_tex    <= unpacked;
      for (int l = 0; l < NUM_LANES; l++) begin
        s1_fu[l] <= req_blends[l*2*FRAC_BITS +: TEX_BLEND_FRAC];
        s1_fv[l] <= req_blends[l*2*FRAC_BITS+FRAC_BITS +: TEX_BLEND_FRAC];
      end
      s2_valid  <= s1_valid;
      s2_mask   <= s1_mask;
      s2_info   <= s1_info;
      s2_h0     <= h0_d;
      s2_h1     <= h1_d;
      s2_fv     <= s1_fv;
      s3_valid  <= s2_valid;
      s3_mask   <= s2_mask;
      s3_info   <= s2_info;
      s3_col    <= lerp_v;
    end
  end

  assign rsp_valid = s3_valid;
  assign rsp_mask  = s3_mask;
  assign rsp_info  = s3_info;

`ifdef TEX_SAMPLER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stalls <= '0;
      perf_reqs   <= '0;
    end else begin
      if (s3_valid && !rsp_ready) perf_stalls <= perf_stalls + 32'd1;
      if (req_valid && req_ready) perf_reqs   <= perf_reqs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tex_sampler.sv
// Randomized bench for tex_sampler with a channel-arithmetic reference model and scoreboard.
module tb_tex_sampler;

  localparam int NL = 4;
  localparam int IW = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic [NL-1:0]     req_mask = '0;
  logic [2:0]        req_format = '0;
  logic              req_filter = 1'b0;
  logic [NL*16-1:0]  req_blends = '0;
  logic [NL*128-1:0] req_data = '0;
  logic [IW-1:0]     req_info = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic [NL-1:0]     rsp_mask;
  logic [NL*32-1:0]  rsp_data;
  logic [IW-1:0]     rsp_info;
  logic              rsp_ready = 1'b1;
`ifdef TEX_SAMPLER_PERF_EN
  logic [31:0]       perf_stalls, perf_reqs;
`endif

  tex_sampler #(.INSTANCE_ID("dut"), .NUM_LANES(NL), .REQ_INFOW(IW), .FRAC_BITS(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_mask(req_mask),
    .req_format(req_format), .req_filter(req_filter), .req_blends(req_blends),
    .req_data(req_data), .req_info(req_info), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_mask(rsp_mask), .rsp_data(rsp_data), .rsp_info(rsp_info),
`ifdef TEX_SAMPLER_PERF_EN
    .perf_stalls(perf_stalls), .perf_reqs(perf_reqs),
`endif
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL*32-1:0] data;
    logic [NL-1:0]    mask;
    logic [IW-1:0]    info;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  int               total = 0, bad = 0;
  int               cyc = 0, rsp_cnt = 0, acc_cnt = 0, last_lat = 0;
  logic [NL*32-1:0] last_data;
  logic [NL-1:0]    last_mask;
  logic [IW-1:0]    last_info;
  bit               hold_chk = 0;
  logic [255:0]     snap;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int expand(int x, int bits);
    case (bits)
      1:       return x * 255;
      4:       return x * 17;
      5:       return x * 8 + x / 4;
      6:       return x * 4 + x / 16;
      default: return x;
    endcase
  endfunction

  function automatic logic [31:0] unpack_ref(int fmt, logic [31:0] t);
    int unsigned v;
    int a, r, g, b;
    v = t;
    a = 0; r = 0; g = 0; b = 0;
    case (fmt)
      0: begin a = (v >> 24) & 255; r = (v >> 16) & 255; g = (v >> 8) & 255; b = v & 255; end
      1: begin a = 255; r = expand((v >> 11) & 31, 5); g = expand((v >> 5) & 63, 6);
               b = expand(v & 31, 5); end
      2: begin a = expand((v >> 15) & 1, 1); r = expand((v >> 10) & 31, 5);
               g = expand((v >> 5) & 31, 5); b = expand(v & 31, 5); end
      3: begin a = expand((v >> 12) & 15, 4); r = expand((v >> 8) & 15, 4);
               g = expand((v >> 4) & 15, 4); b = expand(v & 15, 4); end
      4: begin a = (v >> 8) & 255; r = v & 255; g = r; b = r; end
      5: begin a = 255; r = v & 255; g = r; b = r; end
      6: a = v & 255;
      default: ;
    endcase
    return 32'((a << 24) | (r << 16) | (g << 8) | b);
  endfunction

  function automatic int lerp_ref(int a, int b, int f);
    return (a * (256 - f) + b * f + 128) / 256;
  endfunction

  function automatic logic [NL*32-1:0] model(int fmt, bit filt, logic [NL*16-1:0] bl,
                                             logic [NL*128-1:0] d, logic [NL-1:0] m);
    logic [NL*32-1:0] out;
    logic [31:0] t[4];
    int fu, fv, ch[4], h0, h1, res;
    out = '0;
    for (int l = 0; l < NL; l++) begin
      if (m[l]) begin
        for (int k = 0; k < 4; k++) t[k] = unpack_ref(fmt, d[(l*4+k)*32 +: 32]);
        fu = int'(bl[l*16 +: 8]);
        fv = int'(bl[l*16+8 +: 8]);
        res = 0;
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) ch[k] = int'((t[k] >> (8 * c)) & 32'hFF);
          if (filt) begin
            h0 = lerp_ref(ch[0], ch[1], fu);
            h1 = lerp_ref(ch[2], ch[3], fu);
            res = res | (lerp_ref(h0, h1, fv) << (8 * c));
          end else begin
            res = res | (ch[0] << (8 * c));
          end
        end
        out[l*32 +: 32] = 32'(res);
      end
    end
    return out;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(int fmt, bit filt, logic [NL*16-1:0] bl, logic [NL*128-1:0] d,
                       logic [NL-1:0] m, logic [IW-1:0] info);
    req_valid = 1'b1; req_format = 3'(fmt); req_filter = filt; req_blends = bl;
    req_data = d; req_mask = m; req_info = info;
  endtask

  task automatic drive_rand();
    logic [NL*128-1:0] d;
    logic [NL*16-1:0]  bl;
    for (int k = 0; k < NL * 4; k++) d[k*32 +: 32] = $urandom;
    for (int k = 0; k < NL; k++) bl[k*16 +: 16] = 16'($urandom);
    drive($urandom_range(0, 7), 1'($urandom), bl, d, NL'($urandom), IW'($urandom));
  endtask

  task automatic tick();
    exp_t e;
    #1;
    if (hold_chk) check("rsp_hold", {rsp_valid, rsp_data, rsp_mask, rsp_info}, snap);
    hold_chk = rsp_valid && !rsp_ready;
    snap = {rsp_valid, rsp_data, rsp_mask, rsp_info};
    if (req_valid && req_ready) begin
      e.data = model(req_format, req_filter, req_blends, req_data, req_mask);
      e.mask = req_mask; e.info = req_info; e.cyc = cyc;
      sb.push_back(e);
      acc_cnt++;
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_data", rsp_data, e.data);
        check("sb_mask", rsp_mask, e.mask);
        check("sb_info", rsp_info, e.info);
        last_lat = cyc - e.cyc;
      end
      last_data = rsp_data; last_mask = rsp_mask; last_info = rsp_info;
      rsp_cnt++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic single(int fmt, bit filt, logic [NL*16-1:0] bl, logic [NL*128-1:0] d,
                        logic [NL-1:0] m, logic [IW-1:0] info);
    int n0;
    n0 = rsp_cnt;
    drive(fmt, filt, bl, d, m, info);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && rsp_cnt == n0; i++) tick();
    if (rsp_cnt == n0) check("rsp_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NL*128-1:0] d;
    logic [NL*16-1:0]  bl;
    int n0;

    // Reset state
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_mask", rsp_mask, 0);
    check("rst_rsp_info", rsp_info, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Point, R5G6B5 red
    d = '0; d[31:0] = 32'h0000F800; bl = 16'h1234;
    single(1, 1'b0, bl, d, 4'b0001, 8'hA5);
    check("pt_r565_data", last_data[31:0], 32'hFFFF0000);
    check("pt_r565_info", last_info, 8'hA5);
    check("pt_r565_lat", last_lat, 3);
    check("pt_r565_upper", last_data[127:32], 0);

    // Bilinear half-way blend along u
    d = '0; d[31:0] = 32'hFF000000; d[63:32] = 32'hFFFFFFFF; bl = '0; bl[15:0] = 16'h0080;
    single(0, 1'b1, bl, d, 4'b0001, 8'h3C);
    check("bi_half", last_data[31:0], 32'hFF808080);

    // Uniform texels survive any weights; reserved format unpacks to zero
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NL * 4; k++) d[k*32 +: 32] = 32'h12345678;
      for (int k = 0; k < NL; k++) bl[k*16 +: 16] = 16'($urandom);
      single(0, 1'b1, bl, d, 4'b1111, IW'(i));
      check("uniform", last_data, {NL{32'h12345678}});
    end
    for (int k = 0; k < NL * 4; k++) d[k*32 +: 32] = $urandom;
    single(7, 1'b1, bl, d, 4'b1111, 8'h77);
    check("fmt7_zero", last_data, 0);

    // Masked lanes read zero
    for (int k = 0; k < NL * 4; k++) d[k*32 +: 32] = $urandom | 32'h01010101;
    single(0, 1'b1, bl, d, 4'b0101, 8'h55);
    check("mask_lane1", last_data[63:32], 0);
    check("mask_lane3", last_data[127:96], 0);
    check("mask_out", last_mask, 4'b0101);

    // Back-pressure: three back-to-back, stall 5 cycles on the first response
    n0 = rsp_cnt;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_req_ready", req_ready, 0);
      check("stall_rsp_valid", rsp_valid, 1);
      tick();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 10 && rsp_cnt - n0 < 3; i++) tick();
    check("stall_rsp_count", rsp_cnt - n0, 3);
    check("stall_sb_empty", sb.size(), 0);
`ifdef TEX_SAMPLER_PERF_EN
    check("perf_stalls", perf_stalls, 5);
    check("perf_reqs", perf_reqs, acc_cnt);
`endif

    // Random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) drive_rand();
      else req_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("drain_empty", sb.size(), 0);
`ifdef TEX_SAMPLER_PERF_EN
    check("perf_reqs_rand", perf_reqs, acc_cnt);
`endif

    // Reset with two requests in flight
    drive_rand(); tick();
    drive_rand(); tick();
    req_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    #1;
    check("pre_rst_valid", rsp_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_data", rsp_data, 0);
    sb.delete();
    hold_chk = 0;
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    n0 = rsp_cnt;
    for (int i = 0; i < 8; i++) tick();
    check("post_rst_norsp", rsp_cnt - n0, 0);

    // Pipe still works afterwards
    d = '0; d[31:0] = 32'h000000C3;
    single(5, 1'b0, '0, d, 4'b0001, 8'h11);
    check("post_rst_l8", last_data[31:0], 32'hFFC3C3C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
